// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-hazard bundle between the ID/EX, EX/MEM, MEM/WB registers and the hazard unit.
// Latency: none, wires only.
// Backpressure: carried in-band through pc_write/ifid_write/idex_bubble.
interface hazard_forward_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic            flush;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            id_uses_rt;
    logic [RA_W-1:0] idex_rs;
    logic [RA_W-1:0] idex_rt;
    logic            idex_uses_rt;
    logic [RA_W-1:0] idex_rd;
    logic            idex_memread;
    logic [RA_W-1:0] exmem_rd;
    logic            exmem_regwrite;
    logic [RA_W-1:0] memwb_rd;
    logic            memwb_regwrite;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            pc_write;
    logic            ifid_write;
    logic            idex_bubble;
    logic            stall_active;
    logic [CNT_W-1:0] fwd_count;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: supplies register tags, consumes mux selects and write enables.
    modport master (
        output flush, id_rs, id_rt, id_uses_rt, idex_rs, idex_rt, idex_uses_rt,
               idex_rd, idex_memread, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
        input  fwd_a, fwd_b, pc_write, ifid_write, idex_bubble, stall_active,
               fwd_count, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  flush, id_rs, id_rt, id_uses_rt, idex_rs, idex_rt, idex_uses_rt,
               idex_rd, idex_memread, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
        output fwd_a, fwd_b, pc_write, ifid_write, idex_bubble, stall_active,
               fwd_count, stall_count
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// EX-stage operand forwarding plus load-use stall FSM with saturating activity counters.
// Latency: forwarding and stall outputs are combinational; counters update one cycle later.
// Backpressure: a load-use hazard holds PC and IF/ID and bubbles ID/EX for LOAD_LAT cycles.
module hazard_forward_ctrl #(
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,   // legal 1..7, fits the 3-bit window counter
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    hazard_forward_ctrl_if.slave  hz
);
    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_t           state, state_nxt;
    logic [2:0]       cnt, cnt_nxt;
    logic             ex_a, mem_a, ex_b, mem_b;
    logic             lu;
    logic             stall;
    logic [1:0]       fwd_a_dat, fwd_b_dat;
    logic [CNT_W-1:0] fwd_cnt, stall_cnt;

    // Forward select: youngest producer (EX/MEM) wins; r0 never forwards; rt only if read.
    always_comb begin
        ex_a  = hz.exmem_regwrite && (hz.exmem_rd != '0) && (hz.exmem_rd == hz.idex_rs);
        mem_a = hz.memwb_regwrite && (hz.memwb_rd != '0) && (hz.memwb_rd == hz.idex_rs);
        ex_b  = hz.idex_uses_rt && hz.exmem_regwrite && (hz.exmem_rd != '0)
                && (hz.exmem_rd == hz.idex_rt);
        mem_b = hz.idex_uses_rt && hz.memwb_regwrite && (hz.memwb_rd != '0)
                && (hz.memwb_rd == hz.idex_rt);
        fwd_a_dat = ex_a ? 2'b10 : (mem_a ? 2'b01 : 2'b00);
        fwd_b_dat = ex_b ? 2'b10 : (mem_b ? 2'b01 : 2'b00);
    end

    // Load in ID/EX whose destination is a source of the instruction in IF/ID.
    always_comb begin
        lu = hz.idex_memread && (hz.idex_rd != '0)
             && ((hz.idex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.idex_rd == hz.id_rt)));
    end

    // Stall window sequencing: first cycle served from IDLE, remaining LOAD_LAT-1 in STALL.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        if (hz.flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = LAT_M1;
                        end
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    if (cnt == 3'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating activity counters, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (((fwd_a_dat != 2'b00) || (fwd_b_dat != 2'b00)) && (fwd_cnt != '1))
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.fwd_a        = fwd_a_dat;
    assign hz.fwd_b        = fwd_b_dat;
    assign hz.pc_write     = !stall;
    assign hz.ifid_write   = !stall;
    assign hz.idex_bubble  = stall;
    assign hz.stall_active = (state == STALL);
    assign hz.fwd_count    = fwd_cnt;
    assign hz.stall_count  = stall_cnt;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench: drives one stimulus stream into a LOAD_LAT=1 and a LOAD_LAT=3/CNT_W=4 instance.
// Expected responses are queued per vector; a negedge monitor pops and compares.
// Stimulus is directed with hand-computed expectations.
module tb_hazard_forward_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.RA_W(5), .CNT_W(16)) if1 ();
    hazard_forward_ctrl_if #(.RA_W(5), .CNT_W(4))  if3 ();

    hazard_forward_ctrl #(.RA_W(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clock(clk), .reset(rst), .hz(if1.slave));
    hazard_forward_ctrl #(.RA_W(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (
        .clock(clk), .reset(rst), .hz(if3.slave));

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic [4:0] idex_rs;
        logic [4:0] idex_rt;
        logic       idex_uses_rt;
        logic [4:0] idex_rd;
        logic       idex_memread;
        logic [4:0] exmem_rd;
        logic       exmem_regwrite;
        logic [4:0] memwb_rd;
        logic       memwb_regwrite;
    } in_t;

    // fc/sc = -1 means that counter is not checked for this vector.
    typedef struct {
        string nm;
        int    fa, fb;
        int    s1, s3, sa3;
        int    fc1, sc1, fc3, sc3;
    } exp_t;

    in_t  s;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(string nm, int fa, int fb, int s1, int s3, int sa3,
                                int fc1, int sc1, int fc3, int sc3);
        exp_t e;
        e.nm = nm; e.fa = fa; e.fb = fb; e.s1 = s1; e.s3 = s3; e.sa3 = sa3;
        e.fc1 = fc1; e.sc1 = sc1; e.fc3 = fc3; e.sc3 = sc3;
        return e;
    endfunction

    task automatic apply();
        rst = s.rst;
        if1.flush = s.flush;           if3.flush = s.flush;
        if1.id_rs = s.id_rs;           if3.id_rs = s.id_rs;
        if1.id_rt = s.id_rt;           if3.id_rt = s.id_rt;
        if1.id_uses_rt = s.id_uses_rt; if3.id_uses_rt = s.id_uses_rt;
        if1.idex_rs = s.idex_rs;       if3.idex_rs = s.idex_rs;
        if1.idex_rt = s.idex_rt;       if3.idex_rt = s.idex_rt;
        if1.idex_uses_rt = s.idex_uses_rt; if3.idex_uses_rt = s.idex_uses_rt;
        if1.idex_rd = s.idex_rd;       if3.idex_rd = s.idex_rd;
        if1.idex_memread = s.idex_memread; if3.idex_memread = s.idex_memread;
        if1.exmem_rd = s.exmem_rd;     if3.exmem_rd = s.exmem_rd;
        if1.exmem_regwrite = s.exmem_regwrite; if3.exmem_regwrite = s.exmem_regwrite;
        if1.memwb_rd = s.memwb_rd;     if3.memwb_rd = s.memwb_rd;
        if1.memwb_regwrite = s.memwb_regwrite; if3.memwb_regwrite = s.memwb_regwrite;
    endtask

    task automatic step(input exp_t e);
        @(posedge clk);
        #1;
        apply();
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk({e.nm, ".fwd_a1"}, int'(if1.fwd_a), e.fa);
                chk({e.nm, ".fwd_b1"}, int'(if1.fwd_b), e.fb);
                chk({e.nm, ".fwd_a3"}, int'(if3.fwd_a), e.fa);
                chk({e.nm, ".fwd_b3"}, int'(if3.fwd_b), e.fb);
                chk({e.nm, ".pc_write1"},   int'(if1.pc_write),    1 - e.s1);
                chk({e.nm, ".ifid_write1"}, int'(if1.ifid_write),  1 - e.s1);
                chk({e.nm, ".bubble1"},     int'(if1.idex_bubble), e.s1);
                chk({e.nm, ".stall_act1"},  int'(if1.stall_active), 0);
                chk({e.nm, ".pc_write3"},   int'(if3.pc_write),    1 - e.s3);
                chk({e.nm, ".ifid_write3"}, int'(if3.ifid_write),  1 - e.s3);
                chk({e.nm, ".bubble3"},     int'(if3.idex_bubble), e.s3);
                chk({e.nm, ".stall_act3"},  int'(if3.stall_active), e.sa3);
                if (e.fc1 >= 0) chk({e.nm, ".fwd_count1"},   int'(if1.fwd_count),   e.fc1);
                if (e.sc1 >= 0) chk({e.nm, ".stall_count1"}, int'(if1.stall_count), e.sc1);
                if (e.fc3 >= 0) chk({e.nm, ".fwd_count3"},   int'(if3.fwd_count),   e.fc3);
                if (e.sc3 >= 0) chk({e.nm, ".stall_count3"}, int'(if3.stall_count), e.sc3);
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        s = '0;
        s.rst = 1'b1;
        apply();
        repeat (3) @(posedge clk);

        // Reset state.
        s = '0;
        step(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // EX/MEM beats MEM/WB, then MEM/WB alone.
        s.exmem_rd = 5; s.memwb_rd = 5; s.idex_rs = 5;
        s.exmem_regwrite = 1; s.memwb_regwrite = 1;
        step(mk("fa_both", 2, 0, 0, 0, 0, 0, 0, 0, 0));
        s.exmem_regwrite = 0;
        step(mk("fa_memwb", 1, 0, 0, 0, 0, 1, 0, 1, 0));

        // r0 never forwarded; rt gated by idex_uses_rt.
        s = '0;
        s.idex_uses_rt = 1; s.exmem_regwrite = 1; s.memwb_regwrite = 1;
        step(mk("fb_r0", 0, 0, 0, 0, 0, 2, 0, 2, 0));
        s = '0;
        s.idex_rt = 7; s.exmem_rd = 7; s.exmem_regwrite = 1;
        step(mk("fb_nouse", 0, 0, 0, 0, 0, 2, 0, 2, 0));
        s.idex_uses_rt = 1;
        step(mk("fb_exmem", 0, 2, 0, 0, 0, 2, 0, 2, 0));
        s.exmem_regwrite = 0; s.memwb_rd = 7; s.memwb_regwrite = 1;
        step(mk("fb_memwb", 0, 1, 0, 0, 0, 3, 0, 3, 0));
        s = '0;
        s.memwb_regwrite = 1;
        step(mk("fa_r0", 0, 0, 0, 0, 0, 4, 0, 4, 0));

        // Single load-use on rs: 1-cycle window (LAT1) vs 3-cycle window (LAT3).
        s = '0;
        s.idex_memread = 1; s.idex_rd = 8; s.id_rs = 8;
        step(mk("lu_c1", 0, 0, 1, 1, 0, 4, 0, 4, 0));
        s = '0;
        step(mk("lu_c2", 0, 0, 0, 1, 1, 4, 1, 4, 1));
        step(mk("lu_c3", 0, 0, 0, 1, 1, 4, 1, 4, 2));
        step(mk("lu_c4", 0, 0, 0, 0, 0, 4, 1, 4, 3));

        // Load-use via rt held four cycles: back-to-back windows.
        s.idex_memread = 1; s.idex_rd = 9; s.id_rt = 9; s.id_uses_rt = 1; s.id_rs = 3;
        step(mk("b2b_c1", 0, 0, 1, 1, 0, 4, 1, 4, 3));
        step(mk("b2b_c2", 0, 0, 1, 1, 1, 4, 2, 4, 4));
        step(mk("b2b_c3", 0, 0, 1, 1, 1, 4, 3, 4, 5));
        step(mk("b2b_c4", 0, 0, 1, 1, 0, 4, 4, 4, 6));
        s = '0;
        step(mk("b2b_c5", 0, 0, 0, 1, 1, 4, 5, 4, 7));
        step(mk("b2b_c6", 0, 0, 0, 1, 1, 4, 5, 4, 8));
        step(mk("b2b_c7", 0, 0, 0, 0, 0, 4, 5, 4, 9));

        // No hazard: rt not used, or destination is r0.
        s.idex_memread = 1; s.idex_rd = 9; s.id_rt = 9; s.id_uses_rt = 0; s.id_rs = 3;
        step(mk("nolu_rt", 0, 0, 0, 0, 0, 4, 5, 4, 9));
        s = '0;
        s.idex_memread = 1;
        step(mk("nolu_r0", 0, 0, 0, 0, 0, 4, 5, 4, 9));

        // Flush in the second stall cycle releases at once, then IDLE.
        s = '0;
        s.idex_memread = 1; s.idex_rd = 8; s.id_rs = 8;
        step(mk("fl_c1", 0, 0, 1, 1, 0, 4, 5, 4, 9));
        s.flush = 1;
        step(mk("fl_c2", 0, 0, 0, 0, 1, 4, 6, 4, 10));
        s = '0;
        step(mk("fl_c3", 0, 0, 0, 0, 0, 4, 6, 4, 10));
        s.idex_memread = 1; s.idex_rd = 8; s.id_rs = 8; s.flush = 1;
        step(mk("fl_idle", 0, 0, 0, 0, 0, 4, 6, 4, 10));
        s = '0;
        step(mk("fl_after", 0, 0, 0, 0, 0, 4, 6, 4, 10));

        // Forwarding held 20 cycles: 4-bit counter saturates at 15.
        s.exmem_rd = 5; s.idex_rs = 5; s.exmem_regwrite = 1;
        for (int i = 0; i < 20; i++)
            step(mk($sformatf("sat%0d", i), 2, 0, 0, 0, 0,
                    4 + i, 6, (4 + i > 15) ? 15 : 4 + i, 10));

        // Reset clears all counters on the next edge.
        s = '0;
        s.rst = 1;
        step(mk("rst_in", 0, 0, 0, 0, 0, 24, 6, 15, 10));
        s.rst = 0;
        step(mk("rst_out", 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d vectors left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
